tff_toggle_decoder: RTL and testbench

//   Inverse of T-flop extraction. Recovers the toggle vector T = D ^ Q_prev from a

---
 rtl/tff_toggle_decoder.sv | 143 ++++++++++++++
 tb/tb_tff_toggle_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_toggle_decoder.sv
// Toggle-vector decoder: recovers T = D ^ Q_prev from a stream of D words, with popcount
// and a saturating cumulative toggle count. Optional preset port pair under TFF_DECODE_PRESET_EN.
module tff_toggle_decoder #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      CNT_W = 24,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic                       C,
  input  logic                       CLR,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_t,
  output logic [WIDTH-1:0]           out_q,
  output logic [$clog2(WIDTH+1)-1:0] out_pop,
  output logic                       out_first,
  output logic [CNT_W-1:0]           tog_cnt,
  output logic                       tog_sat
`ifdef TFF_DECODE_PRESET_EN
  ,
  input  logic                       pre,
  input  logic [WIDTH-1:0]           pre_val
`endif
);

  localparam int unsigned POP_W = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] shad_q, shad_d;
  logic             first_q, first_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_t_q, out_t_d;
  logic [WIDTH-1:0] out_q_q, out_q_d;
  logic [POP_W-1:0] out_pop_q, out_pop_d;
  logic             out_first_q, out_first_d;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
  logic             tog_sat_q, tog_sat_d;

  logic             pre_hit;
  logic             in_acc;
  logic             out_acc;
  logic [WIDTH-1:0] tog_c;
  logic [POP_W-1:0] pop_c;
  logic [SUM_W-1:0] sum_c;

`ifdef TFF_DECODE_PRESET_EN
  assign pre_hit = pre;
`else
  assign pre_hit = 1'b0;
`endif

  // A preset cycle blocks input so the reloaded Q is never mixed with an incoming word.
  assign in_ready = (!out_valid_q || out_ready) && !pre_hit;
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;

  assign out_valid = out_valid_q;
  assign out_t     = out_t_q;
  assign out_q     = out_q_q;
  assign out_pop   = out_pop_q;
  assign out_first = out_first_q;
  assign tog_cnt   = tog_cnt_q;
  assign tog_sat   = tog_sat_q;

  // Toggle mask and its popcount for the word at the input.
  always_comb begin
    tog_c = in_d ^ shad_q;
    pop_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop_c = pop_c + POP_W'(tog_c[i]);
    end
  end

  // Next-state logic: counter follows the departing word, output register loads the arriving one.
  always_comb begin
    shad_d      = shad_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_t_d     = out_t_q;
    out_q_d     = out_q_q;
    out_pop_d   = out_pop_q;
    out_first_d = out_first_q;
    tog_cnt_d   = tog_cnt_q;
    tog_sat_d   = tog_sat_q;
    sum_c       = SUM_W'(tog_cnt_q) + SUM_W'(out_pop_q);

    if (out_acc) begin
      if (sum_c >= SUM_W'(CNT_MAX)) begin
        tog_cnt_d = CNT_MAX;
        tog_sat_d = 1'b1;
      end else begin
        tog_cnt_d = CNT_W'(sum_c);
      end
    end

    if (in_acc) begin
      out_valid_d = 1'b1;
      out_t_d     = tog_c;
      out_q_d     = shad_q;
      out_pop_d   = pop_c;
      out_first_d = first_q;
      shad_d      = in_d;
      first_d     = 1'b0;
    end else if (out_acc) begin
      out_valid_d = 1'b0;
    end

`ifdef TFF_DECODE_PRESET_EN
    if (pre_hit) begin
      shad_d  = pre_val;
      first_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      shad_q      <= INIT;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_t_q     <= '0;
      out_q_q     <= '0;
      out_pop_q   <= '0;
      out_first_q <= 1'b0;
      tog_cnt_q   <= '0;
      tog_sat_q   <= 1'b0;
    end else begin
      shad_q      <= shad_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_t_q     <= out_t_d;
      out_q_q     <= out_q_d;
      out_pop_q   <= out_pop_d;
      out_first_q <= out_first_d;
      tog_cnt_q   <= tog_cnt_d;
      tog_sat_q   <= tog_sat_d;
    end
  end

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Bench for tff_toggle_decoder: directed vector table, preset sequence, and randomized
// traffic against a word-level reference model (two instances: 24-bit and 4-bit counter).
module tb_tff_toggle_decoder;

  logic        C = 1'b0;
  logic        CLR = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_d = '0;
  logic        out_ready = 1'b0;
  logic        pre = 1'b0;
  logic [15:0] pre_val = '0;

  logic        in_ready, out_valid, out_first, tog_sat;
  logic [15:0] out_t, out_q;
  logic [4:0]  out_pop;
  logic [23:0] tog_cnt;

  logic        s_in_ready, s_out_valid, s_out_first, s_tog_sat;
  logic [15:0] s_out_t, s_out_q;
  logic [4:0]  s_out_pop;
  logic [3:0]  s_tog_cnt;

  int total = 0;
  int bad = 0;

`ifdef TFF_DECODE_PRESET_EN
  localparam bit HAS_PRE = 1'b1;
`else
  localparam bit HAS_PRE = 1'b0;
`endif

  always #5 C = ~C;

  tff_toggle_decoder #(.WIDTH(16), .CNT_W(24), .INIT(16'h0000)) u_dut (
    .C(C), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready), .in_d(in_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_t(out_t), .out_q(out_q),
    .out_pop(out_pop), .out_first(out_first), .tog_cnt(tog_cnt), .tog_sat(tog_sat)
`ifdef TFF_DECODE_PRESET_EN
    , .pre(pre), .pre_val(pre_val)
`endif
  );

  tff_toggle_decoder #(.WIDTH(16), .CNT_W(4), .INIT(16'h0000)) u_sat (
    .C(C), .CLR(CLR), .in_valid(in_valid), .in_ready(s_in_ready), .in_d(in_d),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_t(s_out_t), .out_q(s_out_q),
    .out_pop(s_out_pop), .out_first(s_out_first), .tog_cnt(s_tog_cnt), .tog_sat(s_tog_sat)
`ifdef TFF_DECODE_PRESET_EN
    , .pre(pre), .pre_val(pre_val)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: last D word, first flag, one pending output word, two clamped sums.
  logic [15:0] m_q;
  bit          m_first, m_ov, m_fst, m_sat, m_sat4;
  logic [15:0] m_t, m_qo;
  int          m_pop;
  longint      m_cnt, m_cnt4;
  localparam longint MAX24 = (64'd1 << 24) - 1;
  localparam longint MAX4  = 15;

  task automatic model_reset();
    m_q = 16'h0000; m_first = 1'b1; m_ov = 1'b0; m_fst = 1'b0;
    m_t = '0; m_qo = '0; m_pop = 0;
    m_cnt = 0; m_cnt4 = 0; m_sat = 1'b0; m_sat4 = 1'b0;
  endtask

  // Drive one cycle at the falling edge, compare against the model, then advance over the rising edge.
  task automatic step(input bit clr, input bit iv, input logic [15:0] d, input bit ordy,
                      input bit pr, input logic [15:0] pv, output bit rdy);
    bit ia, oa, exp_rdy;
    CLR = clr; in_valid = iv; in_d = d; out_ready = ordy; pre = pr; pre_val = pv;
    #1;
    rdy = in_ready;
    exp_rdy = (!m_ov || ordy) && !pr;
    chk("in_ready", in_ready, exp_rdy);
    chk("s_in_ready", s_in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("s_out_valid", s_out_valid, m_ov);
    if (m_ov) begin
      chk("out_t", out_t, m_t);
      chk("s_out_t", s_out_t, m_t);
      chk("out_q", out_q, m_qo);
      chk("out_pop", out_pop, m_pop);
      chk("out_first", out_first, m_fst);
    end
    chk("tog_cnt", tog_cnt, m_cnt);
    chk("tog_sat", tog_sat, m_sat);
    chk("s_tog_cnt", s_tog_cnt, m_cnt4);
    chk("s_tog_sat", s_tog_sat, m_sat4);

    if (clr) begin
      model_reset();
    end else begin
      ia = iv && exp_rdy;
      oa = m_ov && ordy;
      if (oa) begin
        m_cnt  = (m_cnt + m_pop > MAX24) ? MAX24 : m_cnt + m_pop;
        m_cnt4 = (m_cnt4 + m_pop > MAX4) ? MAX4 : m_cnt4 + m_pop;
        if (m_cnt == MAX24) m_sat = 1'b1;
        if (m_cnt4 == MAX4) m_sat4 = 1'b1;
      end
      if (ia) begin
        m_t = d ^ m_q; m_qo = m_q; m_pop = $countones(d ^ m_q);
        m_fst = m_first; m_ov = 1'b1; m_q = d; m_first = 1'b0;
      end else if (oa) begin
        m_ov = 1'b0;
      end
      if (pr) begin
        m_q = pv; m_first = 1'b1;
      end
    end
    @(posedge C);
    @(negedge C);
  endtask

  typedef struct {
    bit          clr, iv;
    logic [15:0] d;
    bit          ordy, e_rdy, e_v;
    logic [15:0] e_t, e_q;
    int          e_pop;
    bit          e_f;
    int          e_cnt, e_cnt4;
    bit          e_sat4;
  } vec_t;

  vec_t vec [20];

  initial begin
    bit rdy;
    vec[0]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 0,  0,  1'b0};
    vec[1]  = '{1'b0, 1'b1, 16'h00FF, 1'b1, 1'b1, 1'b1, 16'h00FF, 16'h0000, 8,  1'b1, 0,  0,  1'b0};
    vec[2]  = '{1'b0, 1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b1, 16'h0FF0, 16'h00FF, 8,  1'b0, 8,  8,  1'b0};
    vec[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 16, 15, 1'b1};
    vec[4]  = '{1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0F0E, 16'h0F0F, 7,  1'b0, 16, 15, 1'b1};
    vec[5]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0F0E, 16'h0F0F, 7,  1'b0, 16, 15, 1'b1};
    vec[6]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h0F0E, 16'h0F0F, 7,  1'b0, 16, 15, 1'b1};
    vec[7]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1, 16'h1235, 16'h0001, 6,  1'b0, 23, 15, 1'b1};
    vec[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 29, 15, 1'b1};
    vec[9]  = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'hEDCB, 16'h1234, 11, 1'b0, 29, 15, 1'b1};
    vec[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 0,  0,  1'b0};
    vec[11] = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0001, 16'h0000, 1,  1'b1, 0,  0,  1'b0};
    vec[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 1,  1,  1'b0};
    vec[13] = '{1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 0,  1'b0, 1,  1,  1'b0};
    vec[14] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 1,  1,  1'b0};
    vec[15] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 0,  0,  1'b0};
    vec[16] = '{1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16, 1'b1, 0,  0,  1'b0};
    vec[17] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16, 1'b0, 16, 15, 1'b1};
    vec[18] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 32, 15, 1'b1};
    vec[19] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 0,  1'b0, 32, 15, 1'b1};

    // Initial reset establishes a known model state.
    CLR = 1'b1;
    @(posedge C);
    @(negedge C);
    model_reset();
    CLR = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vec[i].clr, vec[i].iv, vec[i].d, vec[i].ordy, 1'b0, 16'h0000, rdy);
      chk($sformatf("tbl%0d_in_ready", i), rdy, vec[i].e_rdy);
      chk($sformatf("tbl%0d_out_valid", i), out_valid, vec[i].e_v);
      if (vec[i].e_v) begin
        chk($sformatf("tbl%0d_out_t", i), out_t, vec[i].e_t);
        chk($sformatf("tbl%0d_out_q", i), out_q, vec[i].e_q);
        chk($sformatf("tbl%0d_out_pop", i), out_pop, vec[i].e_pop);
        chk($sformatf("tbl%0d_out_first", i), out_first, vec[i].e_f);
      end
      chk($sformatf("tbl%0d_tog_cnt", i), tog_cnt, vec[i].e_cnt);
      chk($sformatf("tbl%0d_tog_sat", i), tog_sat, 0);
      chk($sformatf("tbl%0d_s_tog_cnt", i), s_tog_cnt, vec[i].e_cnt4);
      chk($sformatf("tbl%0d_s_tog_sat", i), s_tog_sat, vec[i].e_sat4);
    end

    if (HAS_PRE) begin
      // Preset reloads Q and re-arms first; the next word toggles against the preset value.
      step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, rdy);
      step(1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 16'hAAAA, rdy);
      chk("pre_in_ready", rdy, 0);
      chk("pre_no_accept", out_valid, 0);
      step(1'b0, 1'b1, 16'hAAAB, 1'b1, 1'b0, 16'h0000, rdy);
      chk("pre_out_t", out_t, 16'h0001);
      chk("pre_out_q", out_q, 16'hAAAA);
      chk("pre_out_first", out_first, 1);
    end

    // Randomized traffic; occasional clear and (if present) preset.
    for (int i = 0; i < 2000; i++) begin
      bit r_clr, r_pre;
      r_clr = ($urandom_range(63) == 0);
      r_pre = HAS_PRE && ($urandom_range(15) == 0);
      step(r_clr, 1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(3) != 0),
           r_pre, 16'($urandom), rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
